// File: rtl/alu_mul.sv
// alu_mul: single-cycle ALU (ADD/SUB/ADC/SBC/AND/OR/XOR) with a sequential
// unsigned shift-add multiplier sharing one set of registered flags.
//
// Ports
//   CLK            clock, rising edge
//   RESETn         synchronous reset, active-low (priority over CLR/START)
//   CLR            synchronous clear of flags and multiplier state
//   A, B           W-bit operands
//   OP             000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 MUL
//   FIn            flag-write enable, active-low
//   START          multiply start (only honoured with OP=111 and not busy)
//   RESULT         combinational ALU result, or low product half when OP=111
//   HI             high product half
//   CF, ZF, NF, VF registered carry, zero, negative, overflow flags
//   BUSY, DONE     multiply in progress / one-cycle completion pulse
//
// state  | meaning
// S_IDLE | waiting; ALU flag updates and multiply start accepted
// S_RUN  | one shift-add iteration per cycle, W cycles
// S_DONE | product final for one cycle; behaves like S_IDLE otherwise
module alu_mul #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         CLR,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [2:0]   OP,
    input  logic         FIn,
    input  logic         START,
    output logic [W-1:0] RESULT,
    output logic [W-1:0] HI,
    output logic         CF,
    output logic         ZF,
    output logic         NF,
    output logic         VF,
    output logic         BUSY,
    output logic         DONE
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*W-1:0]   p_q, p_d;
    logic [2*W-1:0]   m_q, m_d;       // multiplicand, shifted left each iteration
    logic [W-1:0]     mult_q, mult_d; // multiplier, shifted right each iteration
    logic [CW-1:0]    cnt_q, cnt_d;   // iterations remaining
    logic             cf_q, cf_d, zf_q, zf_d, nf_q, nf_d, vf_q, vf_d;

    logic [W-1:0]     opb;
    logic             cin;
    logic             arith;
    logic [W:0]       sum;
    logic [W-1:0]     alu_res;
    logic             alu_cf, alu_vf;

    // Subtraction is A + ~B + carry-in, so carry=1 means no borrow.
    always_comb begin
        opb   = B;
        cin   = 1'b0;
        arith = 1'b1;
        case (OP)
            3'b000:  begin opb = B;  cin = 1'b0; end
            3'b001:  begin opb = ~B; cin = 1'b1; end
            3'b010:  begin opb = B;  cin = cf_q; end
            3'b011:  begin opb = ~B; cin = cf_q; end
            default: arith = 1'b0;
        endcase
        sum = {1'b0, A} + {1'b0, opb} + {{W{1'b0}}, cin};
        case (OP)
            3'b100:  alu_res = A & B;
            3'b101:  alu_res = A | B;
            3'b110:  alu_res = A ^ B;
            3'b111:  alu_res = p_q[W-1:0];
            default: alu_res = sum[W-1:0];
        endcase
        alu_cf = arith & sum[W];
        alu_vf = arith & (A[W-1] == opb[W-1]) & (sum[W-1] != A[W-1]);
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        mult_d  = mult_q;
        cnt_d   = cnt_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        nf_d    = nf_q;
        vf_d    = vf_q;
        if (CLR) begin
            state_d = S_IDLE;
            p_d     = '0;
            cnt_d   = '0;
            cf_d    = 1'b0;
            zf_d    = 1'b0;
            nf_d    = 1'b0;
            vf_d    = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    p_d    = p_q + (mult_q[0] ? m_q : '0);
                    m_d    = m_q << 1;
                    mult_d = mult_q >> 1;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // last iteration: flags come from the final product
                        state_d = S_DONE;
                        zf_d    = (p_d == '0);
                        cf_d    = |p_d[2*W-1:W];
                        nf_d    = 1'b0;
                        vf_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    if (OP == 3'b111 && START) begin
                        state_d = S_RUN;
                        m_d     = {{W{1'b0}}, A};
                        mult_d  = B;
                        p_d     = '0;
                        cnt_d   = CW'(W);
                    end else if (OP != 3'b111 && !FIn) begin
                        cf_d = alu_cf;
                        vf_d = alu_vf;
                        nf_d = alu_res[W-1];
                        zf_d = (alu_res == '0);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            m_q     <= '0;
            mult_q  <= '0;
            cnt_q   <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            vf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            mult_q  <= mult_d;
            cnt_q   <= cnt_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
            vf_q    <= vf_d;
        end
    end

    assign RESULT = alu_res;
    assign HI     = p_q[2*W-1:W];
    assign CF     = cf_q;
    assign ZF     = zf_q;
    assign NF     = nf_q;
    assign VF     = vf_q;
    assign BUSY   = (state_q == S_RUN);
    assign DONE   = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_mul.sv
module tb_alu_mul;

    localparam int W = 8;
    localparam int M = 1 << W;
    localparam int H = 1 << (W - 1);

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic         CLR = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   OP = 3'b000;
    logic         FIn = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] RESULT, HI;
    logic         CF, ZF, NF, VF, BUSY, DONE;

    alu_mul #(.W(W)) dut (
        .CLK(CLK), .RESETn(RESETn), .CLR(CLR), .A(A), .B(B), .OP(OP),
        .FIn(FIn), .START(START), .RESULT(RESULT), .HI(HI),
        .CF(CF), .ZF(ZF), .NF(NF), .VF(VF), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: integer arithmetic on the operand values.
    bit m_cf, m_zf, m_nf, m_vf, m_done;
    int m_left = 0;   // multiply cycles still to run
    int m_p    = 0;   // visible 2W-bit product
    int m_pend = 0;   // product that will appear when the multiply ends

    function automatic int sgn(input int v);
        return (v >= H) ? v - M : v;
    endfunction

    task automatic alu_model(input int op, input int a, input int b, input bit cin,
                             output int res, output bit c, output bit v);
        int full, sfull;
        bit ar;
        ar = 1'b1; c = 1'b0; sfull = 0;
        case (op)
            0: begin full = a + b;           sfull = sgn(a) + sgn(b);           c = full >= M; end
            1: begin full = a - b;           sfull = sgn(a) - sgn(b);           c = full >= 0; end
            2: begin full = a + b + cin;     sfull = sgn(a) + sgn(b) + cin;     c = full >= M; end
            3: begin full = a - b - 1 + cin; sfull = sgn(a) - sgn(b) - 1 + cin; c = full >= 0; end
            4: begin full = a & b; ar = 1'b0; end
            5: begin full = a | b; ar = 1'b0; end
            default: begin full = a ^ b; ar = 1'b0; end
        endcase
        res = ((full % M) + M) % M;
        v = ar && (sfull < -H || sfull > H - 1);
    endtask

    always @(posedge CLK) begin
        int r;
        bit c, v;
        if (!RESETn) begin
            {m_cf, m_zf, m_nf, m_vf, m_done} = '0;
            m_left = 0; m_p = 0;
        end else if (CLR) begin
            {m_cf, m_zf, m_nf, m_vf, m_done} = '0;
            m_left = 0; m_p = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_p  = m_pend;
                m_zf = (m_pend == 0);
                m_cf = (m_pend / M) != 0;
                m_nf = 1'b0;
                m_vf = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (OP == 3'b111 && START) begin
                m_left = W;
                m_p    = 0;
                m_pend = int'(A) * int'(B);
            end else if (OP != 3'b111 && !FIn) begin
                alu_model(int'(OP), int'(A), int'(B), m_cf, r, c, v);
                m_cf = c; m_vf = v;
                m_nf = r >= H;
                m_zf = (r == 0);
            end
        end
    end

    always @(negedge CLK) begin
        int r;
        bit c, v;
        if (check_en) begin
            chk("BUSY", BUSY, m_left > 0);
            chk("DONE", DONE, m_done);
            chk("CF", CF, m_cf);
            chk("ZF", ZF, m_zf);
            chk("NF", NF, m_nf);
            chk("VF", VF, m_vf);
            if (OP != 3'b111) begin
                alu_model(int'(OP), int'(A), int'(B), m_cf, r, c, v);
                chk("RESULT", RESULT, r);
            end else if (m_left == 0) begin
                chk("RESULT_mul", RESULT, m_p % M);
            end
            if (m_left == 0)
                chk("HI", HI, m_p / M);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_flags(input string tag, input int c, input int z, input int n, input int v);
        chk({tag, "_CF"}, CF, c);
        chk({tag, "_ZF"}, ZF, z);
        chk({tag, "_NF"}, NF, n);
        chk({tag, "_VF"}, VF, v);
    endtask

    initial begin
        RESETn = 1'b0;
        repeat (3) tick();
        RESETn = 1'b1;
        check_en = 1'b1;
        settle();
        chk_flags("rst", 0, 0, 0, 0);
        chk("rst_BUSY", BUSY, 0);
        chk("rst_DONE", DONE, 0);
        chk("rst_HI", HI, 0);

        // ADD 0xFF + 0x01
        OP = 3'b000; A = 8'hFF; B = 8'h01; FIn = 1'b0;
        settle();
        chk("add_RESULT", RESULT, 8'h00);
        tick(); FIn = 1'b1; settle();
        chk_flags("add", 1, 1, 0, 0);

        // SUB 0x80 - 0x01, then a flag-disabled op must not disturb flags
        OP = 3'b001; A = 8'h80; B = 8'h01; FIn = 1'b0;
        settle();
        chk("sub_RESULT", RESULT, 8'h7F);
        tick(); FIn = 1'b1; settle();
        chk_flags("sub", 1, 0, 0, 1);
        OP = 3'b000; A = 8'hFF; B = 8'h01; FIn = 1'b1;
        tick(); settle();
        chk_flags("hold", 1, 0, 0, 1);

        // ADC with CF=1, then SBC with CF=0
        OP = 3'b010; A = 8'h10; B = 8'h20;
        settle();
        chk("adc_RESULT", RESULT, 8'h31);
        OP = 3'b000; A = 8'h01; B = 8'h01; FIn = 1'b0;
        tick(); FIn = 1'b1;
        OP = 3'b011; A = 8'h10; B = 8'h01;
        settle();
        chk("sbc_RESULT", RESULT, 8'h0E);

        // MUL 0xFF * 0xFF, then back-to-back 0x0F * 0x11 from the DONE cycle
        OP = 3'b111; A = 8'hFF; B = 8'hFF; START = 1'b1;
        tick(); START = 1'b0;
        for (int i = 0; i < W; i++) begin
            settle();
            chk("mul1_BUSY", BUSY, 1);
            chk("mul1_DONE", DONE, 0);
            tick();
        end
        A = 8'h0F; B = 8'h11; START = 1'b1;
        settle();
        chk("mul1_DONE_pulse", DONE, 1);
        chk("mul1_BUSY_low", BUSY, 0);
        chk("mul1_RESULT", RESULT, 8'h01);
        chk("mul1_HI", HI, 8'hFE);
        chk("mul1_CF", CF, 1);
        chk("mul1_ZF", ZF, 0);
        tick(); START = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == 3) begin A = 8'h00; B = 8'h00; START = 1'b1; end
            if (i == 4) START = 1'b0;
            settle();
            chk("mul2_BUSY", BUSY, 1);
            tick();
        end
        settle();
        chk("mul2_DONE", DONE, 1);
        chk("mul2_RESULT", RESULT, 8'hFF);
        chk("mul2_HI", HI, 8'h00);
        chk("mul2_CF", CF, 0);
        tick(); settle();
        chk("mul2_DONE_once", DONE, 0);

        // Abort with CLR, then with RESETn, in the 4th busy cycle
        for (int k = 0; k < 2; k++) begin
            OP = 3'b001; A = 8'h80; B = 8'h01; FIn = 1'b0;
            tick(); FIn = 1'b1;
            OP = 3'b111; A = 8'hFF; B = 8'hFF; START = 1'b1;
            tick(); START = 1'b0;
            repeat (3) tick();
            if (k == 0) CLR = 1'b1; else RESETn = 1'b0;
            tick(); CLR = 1'b0; RESETn = 1'b1;
            settle();
            chk("abort_BUSY", BUSY, 0);
            chk("abort_DONE", DONE, 0);
            chk("abort_HI", HI, 0);
            chk_flags("abort", 0, 0, 0, 0);
            for (int i = 0; i < W + 2; i++) begin
                tick(); settle();
                chk("abort_noDONE", DONE, 0);
            end
        end

        // Randomized traffic checked against the model every cycle
        for (int n = 0; n < 4000; n++) begin
            int r;
            tick();
            r      = $urandom_range(0, 9);
            OP     = (r >= 7) ? 3'b111 : 3'(r);
            A      = W'($urandom);
            B      = W'($urandom);
            FIn    = 1'($urandom_range(0, 1));
            START  = ($urandom_range(0, 2) == 0);
            CLR    = ($urandom_range(0, 59) == 0);
            RESETn = ($urandom_range(0, 299) != 0);
        end
        tick();
        CLR = 1'b0; RESETn = 1'b1; START = 1'b0;
        repeat (W + 3) tick();
        check_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mul.md
ALU_MUL -- requirements
Module: alu_mul

Interface
REQ-001 SHALL have parameter W, default 8, giving the operand/result width in bits (W >= 2).
REQ-002 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port RESETn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port CLR  input  1  synchronous clear of flags and multiplier state, active-high.
REQ-005 SHALL have port A  input  W  operand A.
REQ-006 SHALL have port B  input  W  operand B.
REQ-007 SHALL have port OP  input  3  operation select: 000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 MUL.
REQ-008 SHALL have port FIn  input  1  flag-write enable, active-low.
REQ-009 SHALL have port START  input  1  multiply start request, sampled only when OP=111.
REQ-010 SHALL have port RESULT  output  W  operation result (low product half for MUL).
REQ-011 SHALL have port HI  output  W  high product half, registered.
REQ-012 SHALL have ports CF, ZF, NF, VF  output  1 each  registered carry, zero, negative and overflow flags.
REQ-013 SHALL have ports BUSY  output  1  multiply in progress; DONE  output  1  one-cycle completion pulse.

Function
REQ-014 For OP 000-110, RESULT SHALL be combinational from A, B, OP and CF, with no latency.
REQ-015 Arithmetic SHALL be W+1 bits wide: ADD A+B; SUB A+~B+1; ADC A+B+CF; SBC A+~B+CF. Carry-out is bit W, and carry=1 means no borrow for SUB/SBC.
REQ-016 VF SHALL be the signed overflow of the arithmetic result; NF SHALL be RESULT[W-1]; ZF SHALL be (RESULT==0).
REQ-017 For AND, OR and XOR, the next CF and VF SHALL be 0, and NF/ZF SHALL follow REQ-016.
REQ-018 Flags SHALL latch on a clock edge when FIn=0, BUSY=0 and OP!=111; otherwise they hold.
REQ-019 MUL start: START=1, OP=111 and BUSY=0 at an edge SHALL capture A and B and clear the 2W-bit product register P.
REQ-020 MUL operation: an unsigned shift-add multiplier SHALL perform one iteration per cycle, for W iterations, with a counter tracking progress.
REQ-021 BUSY SHALL be high for exactly W cycles, starting the cycle after the START edge.
REQ-022 DONE SHALL pulse high for exactly one cycle, immediately after BUSY falls; P is final in that cycle.
REQ-023 On completion, at the edge where BUSY falls, flags SHALL update regardless of FIn: ZF=(P==0), CF=(P[2W-1:W]!=0), NF=0, VF=0.
REQ-024 START SHALL be ignored while BUSY=1.
REQ-025 START in the DONE cycle SHALL be accepted as a new multiply.
REQ-026 FIn SHALL be ignored while BUSY=1.
REQ-027 When OP=111, RESULT SHALL equal P[W-1:0]; HI SHALL always equal P[2W-1:W].
REQ-028 P SHALL hold its value until the next accepted START, CLR or reset.
REQ-029 CLR=1 at an edge SHALL zero all flags, P and the counter, deassert BUSY, and suppress DONE; this aborts any multiply in progress.
REQ-030 CLR and START together SHALL leave the block idle, with CLR taking priority.

Reset
REQ-031 RESETn=0 at an edge SHALL set CF=ZF=NF=VF=0, BUSY=0, DONE=0, P=0 (HI=0) and the counter to 0, with priority over CLR and START.
REQ-032 Reset mid-multiply SHALL abort the multiply with no DONE pulse.

Verification (W=8)
REQ-033 ADD: A=0xFF, B=0x01, FIn=0 -> RESULT=0x00 same cycle; after the edge CF=1, ZF=1, NF=0, VF=0.
REQ-034 SUB: A=0x80, B=0x01, FIn=0 -> RESULT=0x7F; flags CF=1, VF=1, NF=0, ZF=0. Repeating with FIn=1 leaves the flags unchanged.
REQ-035 ADC with CF=1: A=0x10, B=0x20 -> RESULT=0x31. SBC with CF=0: A=0x10, B=0x01 -> RESULT=0x0E.
REQ-036 MUL: A=0xFF, B=0xFF, START pulse -> BUSY high for 8 cycles, then DONE for 1 cycle; RESULT=0x01, HI=0xFE, CF=1, ZF=0. Back-to-back START in the DONE cycle with 0x0F*0x11 -> RESULT=0xFF, HI=0x00, CF=0.
REQ-037 Abort: CLR asserted in the 4th BUSY cycle -> next cycle BUSY=0, no DONE, HI=0, all flags 0. Repeating the abort with RESETn=0 instead gives the same outcome. START while BUSY has no effect on the result or timing.
